// File: rtl/serial_alu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
//  Module      : serial_alu_ctrl (with full_adder leaf cell)
//  Description : Bit-serial add/subtract sequencer. One shared 1-bit
//                full_adder is walked from bit 0 to bit WIDTH-1, one bit per
//                clock, with a registered carry between bits.
//  Ports       : clk_i/rst_i       clock, synchronous active-high reset
//                start_i/op_i      request and operation (0 add, 1 sub)
//                src1_i/src2_i     operands, latched when start is accepted
//                busy_o/done_o     RUN indicator / one-cycle result strobe
//                result_o          sum or difference
//                cout_o            MSB carry out (sub: 1 = no borrow)
//                overflow_o        two's-complement overflow
//                zero_o            result_o == 0 (valid once a result exists)
//  Revision    : 1.0  initial release
//============================================================================

//----------------------------------------------------------------------------
// 1-bit full adder cell
//----------------------------------------------------------------------------
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

//----------------------------------------------------------------------------
// Bit-serial sequencer around a single full_adder
//----------------------------------------------------------------------------
module serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;       // src2, already inverted for subtract
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_ovf;
    logic               r_valid;   // a completed result is being presented

    logic w_sum;
    logic w_cout;

    // The only adder in the block: one bit per clock.
    full_adder u_full_adder (
        .i_a    (r_a[r_cnt]),
        .i_b    (r_b[r_cnt]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_idle;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts a new start exactly like IDLE so that
                // back-to-back operations need no bubble cycle.
                c_idle, c_done: begin
                    if (start_i) begin
                        r_a     <= src1_i;
                        // Subtract is A + ~B + 1: invert B here and seed
                        // the carry with op_i.
                        r_b     <= src2_i ^ {WIDTH{op_i}};
                        r_carry <= op_i;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_state <= c_run;
                    end else begin
                        r_state <= c_idle;
                    end
                end

                c_run: begin
                    r_result[r_cnt] <= w_sum;
                    r_carry         <= w_cout;
                    if (r_cnt == c_last) begin
                        // r_carry is the carry into the MSB at this point,
                        // so overflow is carry-in(MSB) XOR carry-out(MSB).
                        r_cout  <= w_cout;
                        r_ovf   <= w_cout ^ r_carry;
                        r_valid <= 1'b1;
                        r_state <= c_done;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end

                default: r_state <= c_idle;
            endcase
        end
    end

    assign busy_o     = (r_state == c_run);
    assign done_o     = (r_state == c_done);
    assign result_o   = r_result;
    assign cout_o     = r_cout;
    assign overflow_o = r_ovf;
    // Gated by r_valid so the cleared register after reset does not
    // report a zero result that was never computed.
    assign zero_o     = r_valid && (r_result == '0);

endmodule
`default_nettype wire

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
Bit-serial add/subtract engine that sequences a single shared 1-bit full_adder instance over WIDTH clock cycles, trading latency for area in the Lab ALU datapath. A start/done handshake is used: the block latches the operands, walks bit 0 to bit WIDTH-1 through the full adder with a registered carry, then presents result and flags. It is the control/sequencing wrapper around the existing full_adder cell. It is not a new arithmetic cell.

Parameters:
WIDTH, 32, operand/result width in bits (legal range 2..64)

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  request; sampled only when the FSM is in IDLE or DONE
op_i  input  1  0 = add (src1+src2), 1 = subtract (src1-src2); latched with start_i
src1_i  input  WIDTH  operand A; latched with start_i
src2_i  input  WIDTH  operand B; latched with start_i
busy_o  output  1  high while the FSM is in RUN
done_o  output  1  one-cycle pulse when the result becomes valid
result_o  output  WIDTH  sum/difference; held stable from done_o until the next accepted start
cout_o  output  1  carry out of the MSB; for subtract, 1 = no borrow
overflow_o  output  1  two's-complement overflow
zero_o  output  1  result_o == 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The clock port is clk_i and the reset port is rst_i.
- Reset: when rst_i is high at an edge, FSM -> IDLE, bit counter = 0, carry register = 0, operand/result registers = 0. Outputs after reset: busy_o=0, done_o=0, result_o=0, cout_o=0, overflow_o=0, zero_o=0. rst_i wins over every other input, including start_i and mid-RUN.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_i=1 at edge E0 -> latch src1_i, src2_i XOR {WIDTH{op_i}}, and op_i; set carry register = op_i; set counter = 0; go to RUN.
- RUN: the shared full_adder receives src1=A[cnt], src2=B'[cnt], cin=carry register. At each edge:
  - result[cnt] <= sum
  - carry <= cout
  - cnt <= cnt+1
  - when cnt == WIDTH-1, the carry-in used is also saved as the MSB carry-in (c_msb), and the FSM goes to DONE.
- Counter width: clog2(WIDTH) bits, with no wrap beyond WIDTH-1.
- Latency: bits 0..WIDTH-1 are processed on edges E1..EW. busy_o is high in the cycles after E0 through EW. done_o is high for exactly the one cycle following EW.
- DONE: outputs become valid in this cycle.
  - cout_o = final carry register
  - overflow_o = final carry XOR c_msb
  - zero_o = (result == 0)
  - The FSM returns to IDLE at the next edge, unless start_i=1, in which case it goes directly to RUN and latches new operands (back-to-back, no bubble).
- Output hold: result_o and the flags hold their values through IDLE until the next accepted start. During RUN they are don't-care for the consumer; the implementation drives the partially built register.
- start_i during RUN is ignored and not queued. Operands or op_i changing during RUN have no effect.
- Outputs are registered except done_o, busy_o and zero_o, which are decoded from state and registers. There is no combinational path from start_i to any output.
- Exactly one full_adder instance; no other adder logic.

Test Plan:
- WIDTH=8, add 0x7F+0x01 -> result_o=0x80, cout_o=0, overflow_o=1, zero_o=0; done_o pulses exactly 9 cycles after the start edge, busy_o high for 8 cycles.
- WIDTH=8, add 0xFF+0x01 -> result_o=0x00, cout_o=1, overflow_o=0, zero_o=1.
- WIDTH=8, sub 0x05-0x05 -> 0x00, cout_o=1, zero_o=1, overflow_o=0. Sub 0x80-0x01 -> 0x7F, overflow_o=1, cout_o=1. Sub 0x00-0x01 -> 0xFF, cout_o=0.
- Start pulse and changed operands asserted mid-RUN -> ignored; the result matches the first operands; only one done_o pulse.
- start_i held high during the DONE cycle with new operands (0x10+0x20) -> no IDLE cycle; the next done_o pulse arrives 9 cycles later with result_o=0x30.
- rst_i asserted at RUN bit 3 -> next cycle busy_o=0, done_o=0, result_o=0. A subsequent start (0x03+0x04) completes normally with 0x07.
- WIDTH=32 default, random add/sub x1000 against a reference model -> result_o, cout_o and overflow_o match; latency is always 33 cycles.
